// File: rtl/alu_seq_if.sv
// Operand/result bundle between the sequencer (master) and the ALU (slave).
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             start;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] AI;
  logic [WIDTH-1:0] BI;
  logic             CI;
  logic             D;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             N;
  logic             V;
  logic             Z;
  logic             CO;
  logic             HC;

  modport master (output start, ctrl, AI, BI, CI, D,
                  input  busy, done, out, N, V, Z, CO, HC);
  modport slave  (input  start, ctrl, AI, BI, CI, D,
                  output busy, done, out, N, V, Z, CO, HC);
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: binary ops in one cycle, BCD ADD/SUB one digit per cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, DEC, FIN} state_t;
  state_t r_state, w_next;

  logic             w_busy, w_done, w_accept, w_dec_go, w_sub, w_arith;
  logic [WIDTH-1:0] w_bx, w_res;
  logic [WIDTH:0]   w_ax, w_bxe, w_sum;
  logic             w_co, w_v, w_hc, w_av, w_ahc;

  logic [WIDTH-1:0] r_a, r_b, r_acc, r_out;
  logic [KW-1:0]    r_k;
  logic             r_c, r_sub, r_dv, r_dhc, r_bdone;
  logic             r_n, r_v, r_z, r_co, r_hc;

  logic [3:0]       w_da, w_db, w_dig;
  logic [4:0]       w_s5;
  logic             w_dc, w_dhc, w_last;
  logic [WIDTH-1:0] w_acc;

  // Binary path works straight off the bus; only decimal ops latch operands.
  always_comb begin
    w_sub   = (bus.ctrl == 4'd4);
    w_arith = (bus.ctrl == 4'd0) || w_sub;
    w_bx    = w_sub ? ~bus.BI : bus.BI;
    w_ax    = {1'b0, bus.AI};
    w_bxe   = {1'b0, w_bx};
    w_sum   = w_ax + w_bxe + {{WIDTH{1'b0}}, bus.CI};
    w_av    = (bus.AI[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != bus.AI[WIDTH-1]);
    // carry into bit 4 recovered from the sum bit, no separate nibble adder
    w_ahc   = w_sum[4] ^ w_ax[4] ^ w_bxe[4];
    w_res   = bus.AI;
    w_co    = bus.CI;
    w_v     = 1'b0;
    w_hc    = 1'b0;
    case (bus.ctrl)
      4'd0, 4'd4: begin w_res = w_sum[WIDTH-1:0]; w_co = w_sum[WIDTH]; w_v = w_av; w_hc = w_ahc; end
      4'd1: w_res = bus.AI | bus.BI;
      4'd2: w_res = bus.AI ^ bus.BI;
      4'd3: w_res = bus.AI & bus.BI;
      4'd5: begin w_res = {bus.AI[WIDTH-2:0], 1'b0};   w_co = bus.AI[WIDTH-1]; end
      4'd6: begin w_res = {1'b0, bus.AI[WIDTH-1:1]};   w_co = bus.AI[0];       end
      4'd7: begin w_res = {bus.AI[WIDTH-2:0], bus.CI}; w_co = bus.AI[WIDTH-1]; end
      4'd8: begin w_res = {bus.CI, bus.AI[WIDTH-1:1]}; w_co = bus.AI[0];       end
      default: ;
    endcase
  end

  always_comb begin
    w_da  = r_a[{r_k, 2'b00} +: 4];
    w_db  = r_b[{r_k, 2'b00} +: 4];
    w_dig = 4'd0;
    w_dc  = 1'b0;
    if (r_sub) begin
      // 5-bit two's complement covers -16..15, so bit 4 is the borrow
      w_s5 = {1'b0, w_da} - {1'b0, w_db} - {4'b0, ~r_c};
      if (w_s5[4]) begin w_dig = w_s5[3:0] - 4'd6; w_dc = 1'b0; end
      else         begin w_dig = w_s5[3:0];        w_dc = 1'b1; end
    end else begin
      w_s5 = {1'b0, w_da} + {1'b0, w_db} + {4'b0, r_c};
      if (w_s5 > 5'd9) begin w_dig = w_s5[3:0] + 4'd6; w_dc = 1'b1; end
      else             begin w_dig = w_s5[3:0];        w_dc = 1'b0; end
    end
    w_acc = r_acc;
    w_acc[{r_k, 2'b00} +: 4] = w_dig;
    w_dhc  = (r_k == '0) ? w_dc : r_dhc;
    w_last = (r_k == KW'(NIB - 1));
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_done   = r_bdone;
    w_accept = bus.start && (r_state != DEC);
    w_dec_go = w_accept && w_arith && bus.D;
    case (r_state)
      IDLE: if (w_dec_go) w_next = DEC;
      DEC: begin
        w_busy = 1'b1;
        if (w_last) w_next = FIN;
      end
      FIN: begin
        w_done = 1'b1;
        w_next = w_dec_go ? DEC : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_acc <= '0; r_k <= '0;
      r_c <= 1'b0; r_sub <= 1'b0; r_dv <= 1'b0; r_dhc <= 1'b0; r_bdone <= 1'b0;
      r_out <= '0; r_n <= 1'b0; r_v <= 1'b0; r_z <= 1'b0; r_co <= 1'b0; r_hc <= 1'b0;
    end else begin
      r_bdone <= 1'b0;
      if (w_dec_go) begin
        r_a <= bus.AI; r_b <= bus.BI; r_c <= bus.CI; r_sub <= w_sub;
        r_dv <= w_av; r_k <= '0; r_acc <= '0; r_dhc <= 1'b0;
      end else if (w_accept) begin
        r_out <= w_res; r_n <= w_res[WIDTH-1]; r_z <= (w_res == '0);
        r_co <= w_co; r_v <= w_v; r_hc <= w_hc; r_bdone <= 1'b1;
      end
      if (r_state == DEC) begin
        r_acc <= w_acc; r_c <= w_dc; r_dhc <= w_dhc; r_k <= r_k + KW'(1);
        if (w_last) begin
          r_out <= w_acc; r_n <= w_acc[WIDTH-1]; r_z <= (w_acc == '0);
          r_co <= w_dc; r_v <= r_dv; r_hc <= w_dhc;
        end
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.out  = r_out;
  assign bus.N    = r_n;
  assign bus.V    = r_v;
  assign bus.Z    = r_z;
  assign bus.CO   = r_co;
  assign bus.HC   = r_hc;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: 8- and 16-bit instances against an integer reference model.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct packed {
    logic [15:0] out;
    logic n, v, z, co, hc;
  } res_t;

  typedef struct packed {
    int          w;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        ci, d;
    res_t        exp;
    int          lat;
  } vec_t;

  function automatic res_t model(int w, logic [3:0] op, logic [15:0] a16, logic [15:0] b16,
                                 logic ci, logic d);
    res_t r;
    int a = int'(a16), b = int'(b16), ci_i = int'(ci);
    int mask = (1 << w) - 1;
    int o = 0, co = ci_i, v = 0, hc = 0, bb, s, c, da, db;
    case (op)
      4'd0, 4'd4: begin
        bb = (op == 4'd4) ? (~b & mask) : b;
        s  = a + bb + ci_i;
        v  = (((a >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
             (((s >> (w-1)) & 1) != ((a >> (w-1)) & 1)) ? 1 : 0;
        if (d) begin
          c = ci_i;
          for (int k = 0; k < w/4; k++) begin
            da = (a >> (4*k)) & 15;
            db = (b >> (4*k)) & 15;
            if (op == 4'd0) begin
              s = da + db + c;
              if (s > 9) begin s = s + 6; c = 1; end else c = 0;
            end else begin
              s = da - db - (1 - c);
              if (s < 0) begin s = s - 6; c = 0; end else c = 1;
            end
            o = o | ((s & 15) << (4*k));
            if (k == 0) hc = c;
          end
          co = c;
        end else begin
          o  = s & mask;
          co = (s >> w) & 1;
          hc = (((a & 15) + (bb & 15) + ci_i) >> 4) & 1;
        end
      end
      4'd1: o = a | b;
      4'd2: o = a ^ b;
      4'd3: o = a & b;
      4'd5: begin o = (a << 1) & mask;          co = (a >> (w-1)) & 1; end
      4'd6: begin o = a >> 1;                   co = a & 1; end
      4'd7: begin o = ((a << 1) | ci_i) & mask; co = (a >> (w-1)) & 1; end
      4'd8: begin o = (a >> 1) | (ci_i << (w-1)); co = a & 1; end
      default: o = a;
    endcase
    r.out = o[15:0];
    r.n   = o[w-1];
    r.v   = v[0];
    r.z   = (o == 0);
    r.co  = co[0];
    r.hc  = hc[0];
    return r;
  endfunction

  function automatic res_t sample(int w);
    res_t r;
    if (w == 8) r = '{out: {8'h00, b8.out}, n: b8.N, v: b8.V, z: b8.Z, co: b8.CO, hc: b8.HC};
    else        r = '{out: b16.out, n: b16.N, v: b16.V, z: b16.Z, co: b16.CO, hc: b16.HC};
    return r;
  endfunction

  task automatic drive(int w, logic st, logic [3:0] op, logic [15:0] a, logic [15:0] b,
                       logic ci, logic d);
    b8.start = 1'b0; b16.start = 1'b0;
    if (w == 8) begin
      b8.start = st; b8.ctrl = op; b8.AI = a[7:0]; b8.BI = b[7:0]; b8.CI = ci; b8.D = d;
    end else begin
      b16.start = st; b16.ctrl = op; b16.AI = a; b16.BI = b; b16.CI = ci; b16.D = d;
    end
  endtask

  // Issue one op and follow it to done; lat=0 means done never came.
  task automatic do_op(int w, logic [3:0] op, logic [15:0] a, logic [15:0] b, logic ci,
                       logic d, output int lat, output int bsy_bad, output res_t got);
    logic dec = d && (op == 4'd0 || op == 4'd4);
    logic bz, dn;
    lat = 0; bsy_bad = 0; got = '0;
    @(negedge clk);
    drive(w, 1'b1, op, a, b, ci, d);
    @(negedge clk);
    drive(w, 1'b0, op, a, b, ci, d);
    for (int c = 1; c <= 40; c++) begin
      bz = (w == 8) ? b8.busy : b16.busy;
      dn = (w == 8) ? b8.done : b16.done;
      if (bz !== (dec && c <= w/4)) bsy_bad++;
      if (dn === 1'b1) begin lat = c; got = sample(w); break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(8, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(16, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if ({sample(8), b8.busy, b8.done} !== '0) begin
      bad++; $display("FAIL reset8: got %h want 0", {sample(8), b8.busy, b8.done});
    end
    total++;
    if ({sample(16), b16.busy, b16.done} !== '0) begin
      bad++; $display("FAIL reset16: got %h want 0", {sample(16), b16.busy, b16.done});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    vec_t tbl[7];
    int lat, bb;
    res_t got;
    tbl[0] = '{8,  4'd0, 16'h007F, 16'h0001, 1'b0, 1'b0, '{16'h0080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}, 1};
    tbl[1] = '{8,  4'd0, 16'h0058, 16'h0046, 1'b1, 1'b1, '{16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}, 3};
    tbl[2] = '{8,  4'd4, 16'h0012, 16'h0021, 1'b1, 1'b1, '{16'h0091, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}, 3};
    tbl[3] = '{8,  4'd4, 16'h0000, 16'h0001, 1'b1, 1'b0, '{16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, 1};
    tbl[4] = '{16, 4'd0, 16'h9999, 16'h0001, 1'b0, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}, 5};
    tbl[5] = '{8,  4'd8, 16'h0001, 16'h0000, 1'b1, 1'b0, '{16'h0080, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, 1};
    tbl[6] = '{8,  4'd5, 16'h0080, 16'h0000, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}, 1};
    foreach (tbl[i]) begin
      do_op(tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].d, lat, bb, got);
      total++;
      if (got !== tbl[i].exp) begin
        bad++; $display("FAIL directed%0d result: got %h want %h", i, got, tbl[i].exp);
      end
      total++;
      if (lat != tbl[i].lat || bb != 0) begin
        bad++; $display("FAIL directed%0d timing: lat %0d busyerr %0d want lat %0d", i, lat, bb, tbl[i].lat);
      end
    end
  endtask

  task automatic test_random;
    int lat, bb, w, mask;
    logic [3:0] op;
    logic [15:0] a, b;
    logic ci, d, dec;
    res_t got, exp;
    for (int i = 0; i < 52; i++) begin
      w = (i < 40) ? 8 : 16;
      mask = (1 << w) - 1;
      op = 4'($urandom_range(0, 15));
      if (i % 3 == 0) op = (i % 2 == 0) ? 4'd0 : 4'd4;
      a = 16'($urandom & mask);
      b = 16'($urandom & mask);
      ci = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      dec = d && (op == 4'd0 || op == 4'd4);
      exp = model(w, op, a, b, ci, d);
      do_op(w, op, a, b, ci, d, lat, bb, got);
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rand%0d w%0d op%0d a=%h b=%h ci=%b d=%b: got %h want %h",
                        i, w, op, a, b, ci, d, got, exp);
      end
      total++;
      if (lat != (dec ? w/4 + 1 : 1) || bb != 0) begin
        bad++; $display("FAIL rand%0d timing: lat %0d busyerr %0d want lat %0d",
                        i, lat, bb, dec ? w/4 + 1 : 1);
      end
    end
  endtask

  task automatic test_ignore_start;
    res_t pre, exp, got;
    int lat = 0;
    pre = sample(8);
    exp = model(8, 4'd0, 16'h27, 16'h35, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 1'b1, 4'd0, 16'h27, 16'h35, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 1'b1, 4'd1, 16'hFF, 16'h00, 1'b1, 1'b0);
    total++;
    if (b8.busy !== 1'b1 || sample(8) !== pre) begin
      bad++; $display("FAIL hold: busy %b out %h want busy 1 out %h", b8.busy, sample(8), pre);
    end
    @(negedge clk);
    drive(8, 1'b0, 4'd1, 16'hFF, 16'h00, 1'b1, 1'b0);
    for (int c = 2; c <= 20; c++) begin
      if (b8.done === 1'b1) begin lat = c; got = sample(8); break; end
      @(negedge clk);
    end
    total++;
    if (lat != 3 || got !== exp) begin
      bad++; $display("FAIL ignore_start: lat %0d got %h want lat 3 %h", lat, got, exp);
    end
    @(negedge clk);
    total++;
    if (b8.done !== 1'b0) begin
      bad++; $display("FAIL single_done: done %b want 0", b8.done);
    end
  endtask

  task automatic test_reset_abort;
    int seen = 0, lat, bb;
    res_t got, exp;
    @(negedge clk);
    drive(8, 1'b1, 4'd0, 16'h19, 16'h28, 1'b1, 1'b1);
    @(negedge clk);
    drive(8, 1'b0, 4'd0, 16'h19, 16'h28, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({sample(8), b8.busy, b8.done} !== '0) begin
      bad++; $display("FAIL abort_clear: got %h want 0", {sample(8), b8.busy, b8.done});
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (b8.done !== 1'b0 || b8.busy !== 1'b0) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL abort_quiet: %0d cycles with activity want 0", seen);
    end
    exp = model(8, 4'd4, 16'h50, 16'h07, 1'b1, 1'b1);
    do_op(8, 4'd4, 16'h50, 16'h07, 1'b1, 1'b1, lat, bb, got);
    total++;
    if (got !== exp || lat != 3 || bb != 0) begin
      bad++; $display("FAIL after_abort: got %h lat %0d want %h lat 3", got, lat, exp);
    end
  endtask

  task automatic test_back_to_back;
    res_t e1, e2, e3;
    int lat = 0;
    e1 = model(8, 4'd0, 16'h3C, 16'h4A, 1'b0, 1'b0);
    e2 = model(8, 4'd4, 16'h83, 16'h47, 1'b1, 1'b1);
    e3 = model(8, 4'd2, 16'hA5, 16'h0F, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 1'b1, 4'd0, 16'h3C, 16'h4A, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (b8.done !== 1'b1 || sample(8) !== e1) begin
      bad++; $display("FAIL b2b_first: done %b got %h want %h", b8.done, sample(8), e1);
    end
    drive(8, 1'b1, 4'd4, 16'h83, 16'h47, 1'b1, 1'b1);
    @(negedge clk);
    drive(8, 1'b0, 4'd4, 16'h83, 16'h47, 1'b1, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      if (b8.done === 1'b1) begin lat = c; break; end
      @(negedge clk);
    end
    total++;
    if (lat != 3 || sample(8) !== e2) begin
      bad++; $display("FAIL b2b_dec: lat %0d got %h want lat 3 %h", lat, sample(8), e2);
    end
    drive(8, 1'b1, 4'd2, 16'hA5, 16'h0F, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 1'b0, 4'd2, 16'hA5, 16'h0F, 1'b0, 1'b1);
    total++;
    if (b8.done !== 1'b1 || b8.busy !== 1'b0 || sample(8) !== e3) begin
      bad++; $display("FAIL b2b_fin_start: done %b busy %b got %h want %h", b8.done, b8.busy, sample(8), e3);
    end
    @(negedge clk);
    total++;
    if (b8.done !== 1'b0) begin
      bad++; $display("FAIL b2b_tail: done %b want 0", b8.done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the combinational CPU ALU.
- Width is generic (multiple of 4). Binary ops complete in one cycle. Decimal (BCD) ADD/SUB run digit-serially, one nibble per cycle.
- Full flag set: N, V, Z, C and half carry.
- Sits between the register file/operand muxes and the status register. Controlled by the sequencer through a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of BCD digits (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  launch operation; sampled only when busy=0
- ctrl  in  4  opcode: 0 ADD, 1 OR, 2 XOR, 3 AND, 4 SUB, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9-15 PASS
- AI  in  WIDTH  operand A
- BI  in  WIDTH  operand B
- CI  in  1  carry in (SUB: 1 = no borrow)
- D  in  1  decimal mode; affects ADD/SUB only
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- out  out  WIDTH  registered result
- N  out  1  out[WIDTH-1]
- V  out  1  signed overflow
- Z  out  1  out == 0
- CO  out  1  carry out / shifted-out bit
- HC  out  1  carry out of digit 0

Behaviour:
- Reset: out=0, N=V=Z=CO=HC=0, busy=0, done=0, FSM=IDLE. Reset mid-operation aborts, discards latched operands and suppresses done.
- FSM states: IDLE, DEC, FIN.
- IDLE:
  - start=1 latches ctrl/AI/BI/CI/D.
  - Binary op, or D=0: result computed and registered next edge; done=1 in cycle T+1 (T = start cycle); stay IDLE; busy stays 0.
  - ADD/SUB with D=1: go to DEC with busy=1.
- DEC:
  - Digit k (k=0..NIB-1) is processed at edge T+1+k, LSB digit first. A digit-carry register carries between digits.
  - Move to FIN after the last digit.
  - busy=1 for cycles T+1..T+NIB.
- FIN: done=1 and busy=0 in cycle T+NIB+1; return to IDLE. Decimal latency is NIB+1 cycles.
- start while busy=1 is ignored; no queueing.
- start in the done cycle is accepted (back-to-back).
- Outputs hold their last values until the next operation's done edge. done is never asserted for two consecutive cycles from one start.
- Binary ADD: {CO,out} = AI + BI + CI.
- Binary SUB: {CO,out} = AI + ~BI + CI.
- Binary flags: V = (A[msb]==B'[msb]) && (out[msb]!=A[msb]), where B' = BI for ADD and ~BI for SUB. HC = carry out of bit 3.
- Decimal ADD, per digit: s = a + b + c.
  - If s > 9: s = s + 6, c = 1; else c = 0.
  - Digit = s[3:0].
- Decimal SUB, per digit: s = a - b - (1-c).
  - If s < 0: s = s - 6 (mod 16), c = 0; else c = 1.
- Decimal flags: CO = final c; HC = c after digit 0; V = binary-path overflow of the same operands; N and Z come from the corrected out.
- Invalid BCD digits (>9) follow the same rule deterministically; no error flag.
- Logic ops (OR/XOR/AND/PASS): out = AI op BI (PASS: out = AI); CO = CI; V = 0; HC = 0.
- Shifts operate on AI only:
  - ASL: out = {AI[W-2:0],0}.
  - LSR: out = {0,AI[W-1:1]}.
  - ROL: out = {AI[W-2:0],CI}.
  - ROR: out = {CI,AI[W-1:1]}.
  - CO = shifted-out bit; V = 0; HC = 0.
- D is ignored for every op other than ADD/SUB.

Test Plan:
- WIDTH=8, ADD, D=0, AI=7F, BI=01, CI=0 -> done at T+1, out=80, N=1, V=1, Z=0, CO=0, HC=1, busy never high.
- WIDTH=8, ADD, D=1, AI=58, BI=46, CI=1 -> busy at T+1..T+2, done at T+3, out=05, CO=1, HC=1, Z=0.
- WIDTH=8, SUB, D=1, AI=12, BI=21, CI=1 -> out=91, CO=0, N=1; SUB, D=0, AI=00, BI=01, CI=1 -> out=FF, CO=0, N=1, V=0.
- WIDTH=16, ADD, D=1, AI=9999, BI=0001, CI=0 -> done at T+5, out=0000, CO=1, Z=1, HC=1.
- WIDTH=8, ROR, AI=01, CI=1 -> out=80, CO=1, N=1. Then ASL on AI=80 -> out=00, CO=1, Z=1.
- Decimal ADD started, second start at T+1 with different operands -> ignored, first result delivered. New decimal start, rst at T+1 -> all outputs 0 next edge, no done pulse; a following start behaves normally.
